pipe_stage_hs: RTL and testbench
================================

// Module: pipe_stage_hs
//
// PURPOSE
// Generic parametrised pipeline stage register: successor to fixed inter-stage latches (e.g. EXE->MEM).
// Carries a data payload plus a separately handled control field across a valid/ready handshake.
// Adds stall (backpressure) and synchronous flush (bubble insertion), which plain latches lack.
// Instanced between any two core stages; the control field holds wen/memRead/memWrite/memtoReg/jal-type bits.
//
// PARAMETERS
// DATA_W  106  payload width (alu + waddr + rdata2 + pc for EXE->MEM = DSIZE+ASIZE+DSIZE+ISIZE)
// CTRL_W  5    control width; these bits are forced to 0 in any bubble (reset, flush, !out_valid)
//
// PORTS
// clk        in   1       clock, all state updates on posedge
// rst        in   1       synchronous, active-high reset
// flush      in   1       synchronous kill of all held entries (branch/jump redirect)
// in_valid   in   1       upstream has an entry
// in_ready   out  1       stage can accept; transfer when in_valid && in_ready
// in_ctrl    in   CTRL_W  upstream control bits
// in_data    in   DATA_W  upstream payload
// out_valid  out  1       stage holds an entry for downstream
// out_ready  in   1       downstream accepts; transfer when out_valid && out_ready
// out_ctrl   out  CTRL_W  control bits; 0 whenever out_valid==0
// out_data   out  DATA_W  payload; value undefined-but-stable when out_valid==0 (not X, holds last)
// occ        out  2       number of held entries (0..1, or 0..2 with skid)
//
// BEHAVIOUR
// - Reset (rst=1 at posedge): all valid flags 0, all ctrl and data registers 0; in_ready=1 the cycle after
//   (skid build) / immediately from comb (non-skid). rst has priority over flush and handshakes.
// - Flush (flush=1, rst=0): all entries invalidated, ctrl registers cleared, data registers held.
//   An input accepted in the same cycle is discarded; an output taken in the same cycle is still consumed
//   downstream. Next cycle out_valid=0, occ=0.
// - Latency 1 cycle input-to-output; throughput 1 entry/cycle with out_ready held high.
// - Order preserved; no entry dropped or duplicated except by flush.
// - out_ctrl = valid ? ctrl_reg : 0 (bubble safety: no stray wen/memWrite).
// - Simultaneous accept and release on one entry: new entry replaces old in same posedge.
// - Non-skid: in_ready = !out_valid || out_ready (combinational path from out_ready).
// - Skid: two slots MAIN (drives outputs) and SKID. States by occ: EMPTY(0), ONE(1), FULL(2).
//   EMPTY --accept--> ONE. ONE --accept & !release--> FULL (new entry into SKID).
//   ONE --release & !accept--> EMPTY. ONE --accept & release--> ONE (MAIN<=input).
//   FULL --release--> ONE (MAIN<=SKID). FULL cannot accept (in_ready=0).
//   in_ready = !skid_valid, registered: no comb path out_ready->in_ready.
//
// CONFIGURATION
// PIPE_SKID_EN defined: two-slot skid behaviour above, occ max 2, in_ready registered.
// PIPE_SKID_EN undefined: single slot, in_ready combinational, occ in {0,1}, SKID logic absent.
// Handshake-level behaviour (order, latency, flush, bubble ctrl=0) identical in both builds.
//
// STRUCTURE
// - define.v: DSIZE, ASIZE, ISIZE, and ctrl bit indices (CTRL_WEN, CTRL_MEMRD, CTRL_MEMWR, CTRL_M2R,
//   CTRL_JAL) so all stages pack/unpack the control field identically.
// - Sub-module pipe_slot: one entry (valid, ctrl, data) with load, clear_valid, rst; clears ctrl on
//   rst/flush, data on rst only. Instanced once (MAIN) or twice (MAIN+SKID).
//
// TESTING
// 1 rst=1 two cycles with in_valid=1, in_ctrl=5'h1F -> out_valid=0, out_ctrl=0, out_data=0, occ=0.
// 2 Stream 8 entries data=1..8, out_ready=1 -> outputs 1..8 one cycle after each, no gaps, occ<=1.
// 3 Skid: load 0xA, drop out_ready, present 0xB -> occ=2, in_ready=0 next cycle; raise out_ready ->
//   0xA then 0xB in order, in_ready returns 1 after FULL->ONE.
// 4 Flush with occ=2 and in_valid=1 (data 0xC) -> next cycle out_valid=0, out_ctrl=0, occ=0; 0xC never seen.
// 5 rst and flush together while out_ready=0, occ=1 -> reset values, data regs 0 (rst wins).
// 6 Random valid/ready (10k cycles) vs scoreboard queue: in-order, no loss; ctrl==0 whenever !out_valid.

Source files
------------

// File: rtl/pipe_stage_hs_pkg.sv
// pipe_stage_hs_pkg: shared sizes, control-field bit indices and the skid
// occupancy state type for pipe_stage_hs and its users.
package pipe_stage_hs_pkg;

  localparam int unsigned DSIZE = 32;
  localparam int unsigned ASIZE = 10;
  localparam int unsigned ISIZE = 32;

  localparam int unsigned CTRL_WEN   = 0;
  localparam int unsigned CTRL_MEMRD = 1;
  localparam int unsigned CTRL_MEMWR = 2;
  localparam int unsigned CTRL_M2R   = 3;
  localparam int unsigned CTRL_JAL   = 4;

  localparam int unsigned PIPE_DATA_W = DSIZE + ASIZE + DSIZE + ISIZE;
  localparam int unsigned PIPE_CTRL_W = CTRL_JAL + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  function automatic logic [PIPE_CTRL_W-1:0] ctrl_pack(
    input logic wen,
    input logic memrd,
    input logic memwr,
    input logic m2r,
    input logic jal
  );
    logic [PIPE_CTRL_W-1:0] r;
    r             = '0;
    r[CTRL_WEN]   = wen;
    r[CTRL_MEMRD] = memrd;
    r[CTRL_MEMWR] = memwr;
    r[CTRL_M2R]   = m2r;
    r[CTRL_JAL]   = jal;
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// pipe_stage_hs_if: one valid/ready channel carrying a control field and a
// payload. master drives valid/ctrl/data, slave drives ready.
interface pipe_stage_hs_if
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_hs_slot.sv
// pipe_slot: one pipeline entry (valid, ctrl, data).
//   clk, rst     : clock, synchronous active-high reset (clears everything)
//   flush        : invalidate and clear ctrl, payload held
//   load         : capture ld_ctrl/ld_data and mark valid
//   clear_valid  : entry consumed, drop valid
//   valid/ctrl/data : held entry
// Priority: rst > flush > load > clear_valid.
module pipe_slot
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              clear_valid,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end else if (clear_valid) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline stage register with stall and flush.
//   clk, rst   : clock, synchronous active-high reset (wins over flush)
//   flush      : kill all held entries; an input offered the same cycle is dropped
//   upstream   : slave channel (valid/ctrl/data in, ready out)
//   downstream : master channel (valid/ctrl/data out, ready in);
//                ctrl reads 0 whenever valid is low
//   occ        : number of held entries
// Build option PIPE_SKID_EN: two-slot skid buffer with registered
// upstream.ready (occ 0..2). Undefined: single slot, ready combinational.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_stage_hs_if.slave  upstream,
  pipe_stage_hs_if.master downstream,
  output logic [1:0]      occ
);

  logic              in_ready;
  logic              accept;
  logic              pop;
  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;

  assign accept            = upstream.valid && in_ready;
  assign pop               = main_valid && downstream.ready;
  assign upstream.ready    = in_ready;
  assign downstream.valid  = main_valid;
  assign downstream.ctrl   = main_valid ? main_ctrl : '0;
  assign downstream.data   = main_data;

`ifdef PIPE_SKID_EN

  occ_state_t        state_q;
  occ_state_t        state_d;
  logic              main_load;
  logic              main_from_skid;
  logic              main_clr;
  logic              skid_load;
  logic              skid_clr;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Only a flop drives ready, so out_ready never reaches in_ready combinationally.
  assign in_ready = !skid_valid;
  assign occ      = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept)          state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !pop)          state_d = ST_FULL;
          else if (pop && !accept)     state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop)             state_d = ST_ONE;
        default:                       state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    unique case (state_q)
      ST_EMPTY: main_load = accept;
      ST_ONE: begin
        if (accept && !pop)  skid_load = 1'b1;
        else if (accept)     main_load = 1'b1;
        else if (pop)        main_clr  = 1'b1;
      end
      ST_FULL: begin
        if (pop) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .load        (main_load),
    .clear_valid (main_clr),
    .ld_ctrl     (main_from_skid ? skid_ctrl : upstream.ctrl),
    .ld_data     (main_from_skid ? skid_data : upstream.data),
    .valid       (main_valid),
    .ctrl        (main_ctrl),
    .data        (main_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .load        (skid_load),
    .clear_valid (skid_clr),
    .ld_ctrl     (upstream.ctrl),
    .ld_data     (upstream.data),
    .valid       (skid_valid),
    .ctrl        (skid_ctrl),
    .data        (skid_data)
  );

`else

  assign in_ready = !main_valid || downstream.ready;
  assign occ      = {1'b0, main_valid};

  // load wins over clear_valid inside the slot: accept+pop replaces the entry.
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .load        (accept),
    .clear_valid (pop),
    .ld_ctrl     (upstream.ctrl),
    .ld_data     (upstream.data),
    .valid       (main_valid),
    .ctrl        (main_ctrl),
    .data        (main_data)
  );

`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: scoreboard bench for pipe_stage_hs (either build).
module tb_pipe_stage_hs;
  import pipe_stage_hs_pkg::*;

  localparam int unsigned DW = PIPE_DATA_W;
  localparam int unsigned CW = PIPE_CTRL_W;
`ifdef PIPE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] occ;

  pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .upstream   (up_if),
    .downstream (dn_if),
    .occ        (occ)
  );

  always #5 clk = ~clk;

  // Reference: the stage is a FIFO of capacity CAP; flush/reset empty it.
  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_out = 0;

  logic pend_clear = 1'b0;
  logic pend_push = 1'b0;
  ent_t pend_ent;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // One clock: commit last cycle's model update at posedge, drive at +1,
  // decide this cycle's transfer at negedge (inputs settled).
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    @(posedge clk);
    if (pend_clear) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_ent);
    #1;
    rst         = r;
    flush       = f;
    up_if.valid = iv;
    up_if.ctrl  = c;
    up_if.data  = d;
    dn_if.ready = ordy;
    @(negedge clk);
    pend_clear = r || f;
    pend_push  = iv && up_if.ready && !r && !f;
    pend_ent   = '{ctrl: c, data: d};
  endtask

  // Monitor: compares held/presented entries against the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("occ", 128'(occ), 128'(exp_q.size()));
        chk("out_valid", 128'(dn_if.valid), 128'(exp_q.size() != 0));
        chk("in_ready", 128'(up_if.ready),
            (CAP == 2) ? 128'(exp_q.size() < 2)
                       : 128'((exp_q.size() == 0) || dn_if.ready));
        chk("data_known", 128'($isunknown(dn_if.data)), 128'(0));
        if (!dn_if.valid) begin
          chk("bubble_ctrl", 128'(dn_if.ctrl), 128'(0));
        end else if (exp_q.size() == 0) begin
          chk("unexpected_out", 128'(dn_if.data), 128'(0));
        end else begin
          chk("out_data", 128'(dn_if.data), 128'(exp_q[0].data));
          chk("out_ctrl", 128'(dn_if.ctrl), 128'(exp_q[0].ctrl));
          if (dn_if.ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  initial begin
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    int            base;
    up_if.valid = 1'b0;
    up_if.ctrl  = '0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;

    // Reset held two cycles with an offered entry
    cycle(1'b1, 1'b0, 1'b1, '1, DW'(128'h77), 1'b1);
    cycle(1'b1, 1'b0, 1'b1, '1, DW'(128'h77), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("rst_valid", 128'(dn_if.valid), 128'(0));
    chk("rst_ctrl", 128'(dn_if.ctrl), 128'(0));
    chk("rst_data", 128'(dn_if.data), 128'(0));
    chk("rst_occ", 128'(occ), 128'(0));

    // Stream 1..8 with ready held high
    base = n_out;
    for (int i = 1; i <= 8; i++) begin
      c = ctrl_pack(i[0], i[1], i[2], 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, c, DW'(i), 1'b1);
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("stream_count", 128'(n_out - base), 128'(8));

    // Backpressure: 0xA held, 0xB offered while stalled
    c = ctrl_pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, c, DW'(128'hA), 1'b1);
    cycle(1'b0, 1'b0, 1'b1, c, DW'(128'hB), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
`ifdef PIPE_SKID_EN
    chk("skid_occ2", 128'(occ), 128'(2));
    chk("skid_full_ready", 128'(up_if.ready), 128'(0));
`else
    chk("stall_occ1", 128'(occ), 128'(1));
`endif
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("drain_ready", 128'(up_if.ready), 128'(1));

    // Flush while full with 0xC offered
    cycle(1'b0, 1'b0, 1'b1, c, DW'(128'hD1), 1'b0);
    cycle(1'b0, 1'b0, 1'b1, c, DW'(128'hD2), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, c, DW'(128'hC), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("flush_valid", 128'(dn_if.valid), 128'(0));
    chk("flush_ctrl", 128'(dn_if.ctrl), 128'(0));
    chk("flush_occ", 128'(occ), 128'(0));

    // rst together with flush while stalled, one entry held
    cycle(1'b0, 1'b0, 1'b1, c, DW'(128'hE5), 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("rstflush_data", 128'(dn_if.data), 128'(0));
    chk("rstflush_valid", 128'(dn_if.valid), 128'(0));
    chk("rstflush_occ", 128'(occ), 128'(0));

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      c = ctrl_pack(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      d = DW'({$urandom, $urandom, $urandom, $urandom});
      cycle(1'b0, ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), c, d,
            ($urandom_range(0, 9) < 6));
    end
    for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("final_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
